// File: rtl/gray_code_counter_if.sv
// Control and status bundle for gray_code_counter.
// There is no valid/ready handshake on this bundle: every control input is
// a level sampled on each rising clk edge, and every output except tc is a
// register that updates on that same edge.
interface gray_code_counter_if #(
    parameter int N = 4
);
    logic         clear;
    logic         load;
    logic [N-1:0] load_bin;
    logic         en;
    logic         up_dn;
    logic [N-1:0] gray;
    logic [N-1:0] bin;
    logic         wrap;
    logic         tc;

    // Controller side: drives the controls, observes the count.
    modport master (
        output clear, load, load_bin, en, up_dn,
        input  gray, bin, wrap, tc
    );

    // Counter side.
    modport slave (
        input  clear, load, load_bin, en, up_dn,
        output gray, bin, wrap, tc
    );
endinterface

// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with a registered Gray-code copy.
// Intended as a pointer source for clock-domain crossings: every en-driven
// step, including the wrap steps, flips exactly one gray bit. clear and load
// may flip several bits at once.
// Priority on each edge: clear > load > en. With SATURATE=1 the count holds
// at the range end that matches the current direction instead of wrapping.
module gray_code_counter #(
    parameter int N        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    gray_code_counter_if.slave  bus
);

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] MAX  = '1;

    logic [N-1:0] r_bin;
    logic [N-1:0] r_gray;
    logic         r_wrap;

    logic [N-1:0] w_step_bin;
    logic [N-1:0] w_next_bin;
    logic         w_next_wrap;
    logic         w_tc;

    // Terminal count looks at the live direction so it can flip in the same
    // cycle as up_dn.
    assign w_tc = bus.up_dn ? (r_bin == MAX) : (r_bin == ZERO);

    // One count step in the sampled direction, modulo 2^N.
    assign w_step_bin = bus.up_dn ? (r_bin + ONE) : (r_bin - ONE);

    // Next-state selection for the binary count and the wrap pulse.
    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        if (bus.clear) begin
            w_next_bin = ZERO;
        end else if (bus.load) begin
            w_next_bin = bus.load_bin;
        end else if (bus.en) begin
            if (!SATURATE) begin
                // Wrap mode: a step taken at the terminal count is the wrap.
                w_next_bin  = w_step_bin;
                w_next_wrap = w_tc;
            end else if (!w_tc) begin
                // Saturate mode steps freely away from the ends, holds at them.
                w_next_bin = w_step_bin;
            end
        end
    end

    // State registers; gray is encoded from next_bin so it never lags bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= ZERO;
            r_gray <= ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_bin ^ (w_next_bin >> 1);
            r_wrap <= w_next_wrap;
        end
    end

    assign bus.bin  = r_bin;
    assign bus.gray = r_gray;
    assign bus.wrap = r_wrap;
    assign bus.tc   = w_tc;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: one wrapping and one saturating
// instance share clock, reset and control values; each is checked against
// hand-computed expectations at the falling edge.
module tb_gray_code_counter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gray_code_counter_if #(.N(N)) if_w ();
    gray_code_counter_if #(.N(N)) if_s ();

    gray_code_counter #(.N(N), .SATURATE(1'b0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w)
    );

    gray_code_counter #(.N(N), .SATURATE(1'b1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Gray sequence for bin = 0..15, hand-written.
    logic [3:0] exp_gray [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Same control values to both instances.
    task automatic drive(input logic c, input logic l, input logic [N-1:0] lb,
                         input logic e, input logic u);
        if_w.clear = c; if_w.load = l; if_w.load_bin = lb; if_w.en = e; if_w.up_dn = u;
        if_s.clear = c; if_s.load = l; if_s.load_bin = lb; if_s.en = e; if_s.up_dn = u;
    endtask

    // One rising edge, then settle at the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_w(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
        check({tag, "_w_bin"},  32'(if_w.bin),  32'(b));
        check({tag, "_w_gray"}, 32'(if_w.gray), 32'(g));
        check({tag, "_w_wrap"}, 32'(if_w.wrap), 32'(w));
    endtask

    task automatic check_s(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
        check({tag, "_s_bin"},  32'(if_s.bin),  32'(b));
        check({tag, "_s_gray"}, 32'(if_s.gray), 32'(g));
        check({tag, "_s_wrap"}, 32'(if_s.wrap), 32'(w));
    endtask

    initial begin
        logic [3:0] prev_gray;

        // ---- reset ----
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #12;
        check_w("rst", 4'd0, 4'd0, 1'b0);
        check_s("rst", 4'd0, 4'd0, 1'b0);
        check("rst_tc_up", 32'(if_w.tc), 32'd0);
        if_w.up_dn = 1'b0;
        #1;
        check("rst_tc_dn", 32'(if_w.tc), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- up sequence, 17 steps ----
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        prev_gray = 4'd0;
        for (int i = 1; i <= 17; i++) begin
            if (i == 16) check("up_tc_at15", 32'(if_w.tc), 32'd1);
            tick();
            check_w($sformatf("up%0d", i), 4'(i % 16), exp_gray[i % 16], (i == 16));
            check($sformatf("up%0d_onebit", i), 32'($countones(if_w.gray ^ prev_gray)), 32'd1);
            prev_gray = if_w.gray;
        end
        check_s("up_sat_hold", 4'd15, 4'b1000, 1'b0);

        // ---- down wrap from reset ----
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        check("dn_tc_at0", 32'(if_w.tc), 32'd1);
        if_w.en = 1'b1; if_s.en = 1'b1;
        tick();
        check_w("dn1", 4'd15, 4'b1000, 1'b1);
        check_s("dn1", 4'd0, 4'd0, 1'b0);
        tick();
        check_w("dn2", 4'd14, 4'b1001, 1'b0);

        // ---- load wins over en; clear wins over load ----
        drive(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
        tick();
        check_w("load", 4'b1010, 4'b1111, 1'b0);
        check_s("load", 4'b1010, 4'b1111, 1'b0);
        drive(1'b1, 1'b1, 4'b0111, 1'b1, 1'b1);
        tick();
        check_w("clr_load", 4'd0, 4'd0, 1'b0);
        check_s("clr_load", 4'd0, 4'd0, 1'b0);

        // ---- saturate at top, then step down ----
        drive(1'b0, 1'b1, 4'b1110, 1'b0, 1'b1);
        tick();
        check_s("sat_load", 4'b1110, 4'b1001, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        check_s("sat1", 4'b1111, 4'b1000, 1'b0);
        check_w("sat1", 4'b1111, 4'b1000, 1'b0);
        tick();
        check_s("sat2", 4'b1111, 4'b1000, 1'b0);
        check_w("sat2", 4'b0000, 4'b0000, 1'b1);
        tick();
        check_s("sat3", 4'b1111, 4'b1000, 1'b0);
        check("sat3_tc", 32'(if_s.tc), 32'd1);
        check_w("sat3", 4'b0001, 4'b0001, 1'b0);
        if_w.up_dn = 1'b0; if_s.up_dn = 1'b0;
        tick();
        check_s("sat_dn", 4'b1110, 4'b1001, 1'b0);
        check_w("sat_dn", 4'b0000, 4'b0000, 1'b0);

        // ---- asynchronous reset mid-count ----
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check_w("pre_rst", 4'b0101, 4'b0111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_w("mid_rst", 4'd0, 4'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        check_w("post_rst", 4'd1, 4'b0001, 1'b0);

        // ---- enable gating with up_dn toggling ----
        drive(1'b0, 1'b1, 4'b0011, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if_w.up_dn = i[0]; if_s.up_dn = i[0];
            tick();
            check_w($sformatf("hold%0d", i), 4'b0011, 4'b0010, 1'b0);
            check($sformatf("hold%0d_tc", i), 32'(if_w.tc), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
